// File: rtl/auction_winner_scan_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// auction_winner_scan_if
//
// Bundle of the bid handshake and result signals of auction_winner_scan.
//
// Parameters:
//   N  index width; the auction has 2**N bidders
//   W  bid width in bits (unsigned)
//
// Signals:
//   start          single-cycle pulse that begins a new auction
//   bid_valid      a bid is present on bid
//   bid[W]         bid of the bidder whose number equals the accept count
//   bid_ready      scanner can accept a bid this cycle
//   done           results valid; held until the next start
//   winner_idx[N]  index of the highest bidder (mux select / decoder input)
//   winner_onehot  one-hot of winner_idx while done, zero otherwise
//   winner_bid[W]  highest bid
//   second_bid[W]  second-highest bid (constant 0 unless second-price build)
//
// Modports:
//   master  bid source / result consumer
//   slave   the scanner itself
// -----------------------------------------------------------------------------
interface auction_winner_scan_if #(
  parameter int N = 3,
  parameter int W = 8
);
  logic                  start;
  logic                  bid_valid;
  logic [W-1:0]          bid;
  logic                  bid_ready;
  logic                  done;
  logic [N-1:0]          winner_idx;
  logic [(1<<N)-1:0]     winner_onehot;
  logic [W-1:0]          winner_bid;
  logic [W-1:0]          second_bid;

  modport master (
    output start, bid_valid, bid,
    input  bid_ready, done, winner_idx, winner_onehot, winner_bid, second_bid
  );

  modport slave (
    input  start, bid_valid, bid,
    output bid_ready, done, winner_idx, winner_onehot, winner_bid, second_bid
  );
endinterface

// File: rtl/auction_winner_scan.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// auction_winner_scan
//
// Sequential arg-max over 2**N bids delivered one per handshake. Keeps a
// running maximum (lowest index wins ties) and, optionally, the runner-up
// value used as the Vickrey clearing price.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    auction_winner_scan_if.slave (start, bid_valid, bid in;
//          bid_ready, done, winner_idx, winner_onehot, winner_bid,
//          second_bid out). Every output is a flop.
//
// Build option:
//   AUCTION_SECOND_PRICE_EN  when defined, second_bid tracks the
//                            second-highest bid; otherwise it is tied to 0
//                            and no runner-up register/comparator exists.
// -----------------------------------------------------------------------------
module auction_winner_scan #(
  parameter int N = 3,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  auction_winner_scan_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        count_q, count_d;
  logic [N-1:0]        idx_q, idx_d;
  logic [W-1:0]        win_q, win_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic [(1<<N)-1:0]   onehot_q, onehot_d;

  logic clear;   // start seen outside SCAN: wipe results, begin scanning
  logic accept;  // handshake completes this cycle
  logic first;   // the accepted bid is bidder 0
  logic last;    // the accepted bid is the final bidder

  // ready_q is only ever high in SCAN, so it also qualifies the state.
  assign clear  = bus.start && (state_q != SCAN);
  assign accept = bus.bid_valid && ready_q;
  assign first  = (count_q == '0);
  assign last   = &count_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output is given a default before any branch;
  // a path that leaves it unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start)      state_d = SCAN;
      SCAN:    if (accept && last) state_d = DONE;
      DONE:    if (bus.start)      state_d = SCAN;
      default:                     state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic. Status outputs are decoded from the next state and
  // registered, so they change on the same edge as the state itself.
  // ---------------------------------------------------------------------------
  always_comb begin
    ready_d  = (state_d == SCAN);
    done_d   = (state_d == DONE);
    onehot_d = '0;
    if (done_d) onehot_d[idx_d] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Running maximum
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    idx_d   = idx_q;
    win_d   = win_q;
    if (clear) begin
      count_d = '0;
      idx_d   = '0;
      win_d   = '0;
    end else if (accept) begin
      count_d = count_q + N'(1);   // wraps to 0 after the last bidder
      if (first) begin
        win_d = bus.bid;
        idx_d = '0;
      end else if (bus.bid > win_q) begin
        // Strict compare: an equal bid never displaces the lower index.
        win_d = bus.bid;
        idx_d = count_q;
      end
    end
  end

  // NOTE: this block holds only a handful of flops, so all of them take the
  // asynchronous reset; outputs read 0 the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      idx_q    <= '0;
      win_q    <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      onehot_q <= '0;
    end else begin
      count_q  <= count_d;
      idx_q    <= idx_d;
      win_q    <= win_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      onehot_q <= onehot_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Runner-up price
  // ---------------------------------------------------------------------------
`ifdef AUCTION_SECOND_PRICE_EN
  logic [W-1:0] sec_q, sec_d;

  // Keeps the top two values of the bid multiset: a displaced maximum drops
  // to second place, and a bid equal to the maximum still counts as second.
  always_comb begin
    sec_d = sec_q;
    if (clear) begin
      sec_d = '0;
    end else if (accept) begin
      if (first)                  sec_d = '0;
      else if (bus.bid > win_q)   sec_d = win_q;
      else if (bus.bid > sec_q)   sec_d = bus.bid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sec_q <= '0;
    else        sec_q <= sec_d;
  end

  assign bus.second_bid = sec_q;
`else
  assign bus.second_bid = '0;
`endif

  assign bus.bid_ready     = ready_q;
  assign bus.done          = done_q;
  assign bus.winner_idx    = idx_q;
  assign bus.winner_onehot = onehot_q;
  assign bus.winner_bid    = win_q;

endmodule

// File: tb/tb_auction_winner_scan.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_auction_winner_scan
//
// Two scanners share clock and reset: dut2 (N=2, four bidders) for the
// directed scenarios and dut3 (N=3, eight bidders) for the ascending sweep
// and randomized auctions. Inputs are driven on the falling edge, outputs
// sampled on the falling edge. Expected results come from ref_auction, which
// derives winner and runner-up directly from the list of bids.
// -----------------------------------------------------------------------------
module tb_auction_winner_scan;

`ifdef AUCTION_SECOND_PRICE_EN
  localparam bit SECOND_EN = 1'b1;
`else
  localparam bit SECOND_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  auction_winner_scan_if #(.N(2), .W(8)) ifc2 ();
  auction_winner_scan_if #(.N(3), .W(8)) ifc3 ();

  auction_winner_scan #(.N(2), .W(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(ifc2));
  auction_winner_scan #(.N(3), .W(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(ifc3));

  // Winner = lowest index holding the maximum value; runner-up = largest
  // value among all other bidders (0 when the price option is off).
  function automatic void ref_auction(input int unsigned bids[$],
                                      output int unsigned idx,
                                      output int unsigned top,
                                      output int unsigned second);
    int unsigned mx = 0;
    bit found = 1'b0;
    foreach (bids[i]) if (bids[i] > mx) mx = bids[i];
    idx = 0;
    foreach (bids[i]) if (!found && bids[i] == mx) begin idx = i; found = 1'b1; end
    top = mx;
    second = 0;
    foreach (bids[i]) if (i != idx && bids[i] > second) second = bids[i];
    if (!SECOND_EN) second = 0;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic start2();
    ifc2.start = 1'b1;
    @(negedge clk);
    ifc2.start = 1'b0;
  endtask

  task automatic start3();
    ifc3.start = 1'b1;
    @(negedge clk);
    ifc3.start = 1'b0;
  endtask

  task automatic send2(input logic [7:0] b);
    int waited = 0;
    while (ifc2.bid_ready !== 1'b1 && waited < 50) begin @(negedge clk); waited++; end
    if (ifc2.bid_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send2_timeout: bid_ready=%b, required 1 within 50 cycles", ifc2.bid_ready);
    end else begin
      ifc2.bid_valid = 1'b1;
      ifc2.bid       = b;
      @(negedge clk);
      ifc2.bid_valid = 1'b0;
    end
  endtask

  task automatic send3(input logic [7:0] b);
    int waited = 0;
    while (ifc3.bid_ready !== 1'b1 && waited < 50) begin @(negedge clk); waited++; end
    if (ifc3.bid_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send3_timeout: bid_ready=%b, required 1 within 50 cycles", ifc3.bid_ready);
    end else begin
      ifc3.bid_valid = 1'b1;
      ifc3.bid       = b;
      @(negedge clk);
      ifc3.bid_valid = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({ifc2.bid_ready, ifc2.done, ifc2.winner_idx, ifc2.winner_onehot,
         ifc2.winner_bid, ifc2.second_bid} !== '0) begin
      errors++;
      $display("FAIL reset_dut2: outputs ready=%b done=%b idx=%0d oh=%b win=%0d sec=%0d, required all 0",
               ifc2.bid_ready, ifc2.done, ifc2.winner_idx, ifc2.winner_onehot, ifc2.winner_bid, ifc2.second_bid);
    end
    checks++;
    if ({ifc3.bid_ready, ifc3.done, ifc3.winner_idx, ifc3.winner_onehot,
         ifc3.winner_bid, ifc3.second_bid} !== '0) begin
      errors++;
      $display("FAIL reset_dut3: outputs ready=%b done=%b idx=%0d oh=%b win=%0d sec=%0d, required all 0",
               ifc3.bid_ready, ifc3.done, ifc3.winner_idx, ifc3.winner_onehot, ifc3.winner_bid, ifc3.second_bid);
    end
    rst_n = 1'b1;
    // bid_valid in IDLE must be ignored
    ifc2.bid_valid = 1'b1;
    ifc2.bid       = 8'd99;
    repeat (2) @(negedge clk);
    ifc2.bid_valid = 1'b0;
    checks++;
    if (ifc2.bid_ready !== 1'b0 || ifc2.done !== 1'b0 || ifc2.winner_bid !== 8'd0) begin
      errors++;
      $display("FAIL idle_ignores_valid: ready=%b done=%b win=%0d, required 0 0 0",
               ifc2.bid_ready, ifc2.done, ifc2.winner_bid);
    end
  endtask

  task automatic test_distinct_max();
    start2();
    checks++;
    if (ifc2.bid_ready !== 1'b1 || ifc2.done !== 1'b0) begin
      errors++;
      $display("FAIL distinct_enter_scan: ready=%b done=%b, required 1 0", ifc2.bid_ready, ifc2.done);
    end
    send2(8'd3); send2(8'd17); send2(8'd8);
    checks++;
    if (ifc2.done !== 1'b0) begin
      errors++;
      $display("FAIL distinct_early_done: done=%b before last accept, required 0", ifc2.done);
    end
    send2(8'd12);
    checks++;
    if (ifc2.done !== 1'b1 || ifc2.bid_ready !== 1'b0 || ifc2.winner_idx !== 2'd1 ||
        ifc2.winner_onehot !== 4'b0010 || ifc2.winner_bid !== 8'd17) begin
      errors++;
      $display("FAIL distinct_result: done=%b ready=%b idx=%0d oh=%b win=%0d, required 1 0 1 0010 17",
               ifc2.done, ifc2.bid_ready, ifc2.winner_idx, ifc2.winner_onehot, ifc2.winner_bid);
    end
    checks++;
    if (ifc2.second_bid !== (SECOND_EN ? 8'd12 : 8'd0)) begin
      errors++;
      $display("FAIL distinct_second: got %0d, required %0d", ifc2.second_bid, SECOND_EN ? 12 : 0);
    end
  endtask

  task automatic test_tie();
    start2();
    send2(8'd20); send2(8'd7); send2(8'd20); send2(8'd1);
    checks++;
    if (ifc2.done !== 1'b1 || ifc2.winner_idx !== 2'd0 || ifc2.winner_onehot !== 4'b0001 ||
        ifc2.winner_bid !== 8'd20) begin
      errors++;
      $display("FAIL tie_result: done=%b idx=%0d oh=%b win=%0d, required 1 0 0001 20",
               ifc2.done, ifc2.winner_idx, ifc2.winner_onehot, ifc2.winner_bid);
    end
    checks++;
    if (ifc2.second_bid !== (SECOND_EN ? 8'd20 : 8'd0)) begin
      errors++;
      $display("FAIL tie_second: got %0d, required %0d", ifc2.second_bid, SECOND_EN ? 20 : 0);
    end
  endtask

  task automatic test_stall_ignored_start();
    start2();
    send2(8'd4);
    @(negedge clk);
    ifc2.start = 1'b1;          // must be ignored in SCAN
    @(negedge clk);
    ifc2.start = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc2.bid_ready !== 1'b1 || ifc2.done !== 1'b0 || ifc2.winner_bid !== 8'd4) begin
      errors++;
      $display("FAIL stall_hold: ready=%b done=%b win=%0d, required 1 0 4",
               ifc2.bid_ready, ifc2.done, ifc2.winner_bid);
    end
    send2(8'd4);
    repeat (3) @(negedge clk);
    send2(8'd200);
    repeat (3) @(negedge clk);
    checks++;
    if (ifc2.done !== 1'b0) begin
      errors++;
      $display("FAIL stall_early_done: done=%b after 3 accepts, required 0", ifc2.done);
    end
    send2(8'd0);
    checks++;
    if (ifc2.done !== 1'b1 || ifc2.winner_idx !== 2'd2 || ifc2.winner_onehot !== 4'b0100 ||
        ifc2.winner_bid !== 8'd200 || ifc2.second_bid !== (SECOND_EN ? 8'd4 : 8'd0)) begin
      errors++;
      $display("FAIL stall_result: done=%b idx=%0d oh=%b win=%0d sec=%0d, required 1 2 0100 200 %0d",
               ifc2.done, ifc2.winner_idx, ifc2.winner_onehot, ifc2.winner_bid, ifc2.second_bid,
               SECOND_EN ? 4 : 0);
    end
  endtask

  task automatic test_back_to_back();
    repeat (2) @(negedge clk);
    checks++;
    if (ifc2.done !== 1'b1 || ifc2.winner_bid !== 8'd200) begin
      errors++;
      $display("FAIL b2b_hold: done=%b win=%0d, required 1 200", ifc2.done, ifc2.winner_bid);
    end
    start2();
    checks++;
    if (ifc2.done !== 1'b0 || ifc2.bid_ready !== 1'b1 || ifc2.winner_onehot !== 4'b0000 ||
        ifc2.winner_bid !== 8'd0 || ifc2.winner_idx !== 2'd0 || ifc2.second_bid !== 8'd0) begin
      errors++;
      $display("FAIL b2b_restart: done=%b ready=%b oh=%b win=%0d idx=%0d sec=%0d, required 0 1 0000 0 0 0",
               ifc2.done, ifc2.bid_ready, ifc2.winner_onehot, ifc2.winner_bid, ifc2.winner_idx, ifc2.second_bid);
    end
    for (int i = 0; i < 4; i++) send2(8'd0);
    checks++;
    if (ifc2.done !== 1'b1 || ifc2.winner_idx !== 2'd0 || ifc2.winner_onehot !== 4'b0001 ||
        ifc2.winner_bid !== 8'd0 || ifc2.second_bid !== 8'd0) begin
      errors++;
      $display("FAIL b2b_zero_result: done=%b idx=%0d oh=%b win=%0d sec=%0d, required 1 0 0001 0 0",
               ifc2.done, ifc2.winner_idx, ifc2.winner_onehot, ifc2.winner_bid, ifc2.second_bid);
    end
  endtask

  task automatic test_reset_mid_scan();
    start2();
    send2(8'd5); send2(8'd9);
    checks++;
    if (ifc2.winner_bid !== 8'd9 || ifc2.winner_idx !== 2'd1) begin
      errors++;
      $display("FAIL midscan_partial: win=%0d idx=%0d, required 9 1", ifc2.winner_bid, ifc2.winner_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ifc2.bid_ready, ifc2.done, ifc2.winner_idx, ifc2.winner_onehot,
         ifc2.winner_bid, ifc2.second_bid} !== '0) begin
      errors++;
      $display("FAIL midscan_async_clear: ready=%b done=%b idx=%0d oh=%b win=%0d sec=%0d, required all 0",
               ifc2.bid_ready, ifc2.done, ifc2.winner_idx, ifc2.winner_onehot, ifc2.winner_bid, ifc2.second_bid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ifc2.bid_ready !== 1'b0 || ifc2.done !== 1'b0) begin
      errors++;
      $display("FAIL midscan_idle: ready=%b done=%b, required 0 0", ifc2.bid_ready, ifc2.done);
    end
  endtask

  task automatic test_ascending();
    start3();
    for (int i = 1; i <= 8; i++) send3(8'(i));
    checks++;
    if (ifc3.done !== 1'b1 || ifc3.winner_idx !== 3'd7 || ifc3.winner_onehot !== 8'h80 ||
        ifc3.winner_bid !== 8'd8 || ifc3.second_bid !== (SECOND_EN ? 8'd7 : 8'd0)) begin
      errors++;
      $display("FAIL ascending_result: done=%b idx=%0d oh=%h win=%0d sec=%0d, required 1 7 80 8 %0d",
               ifc3.done, ifc3.winner_idx, ifc3.winner_onehot, ifc3.winner_bid, ifc3.second_bid,
               SECOND_EN ? 7 : 0);
    end
  endtask

  task automatic test_random();
    for (int a = 0; a < 12; a++) begin
      int unsigned bids[$];
      int unsigned e_idx, e_top, e_sec;
      logic [7:0]  e_oh;
      bids.delete();
      for (int i = 0; i < 8; i++)
        bids.push_back((a % 2 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 3));
      ref_auction(bids, e_idx, e_top, e_sec);
      e_oh = 8'b1 << e_idx;
      start3();
      for (int i = 0; i < 8; i++) begin
        if (i == 7) begin
          checks++;
          if (ifc3.done !== 1'b0) begin
            errors++;
            $display("FAIL rand%0d_early_done: done=%b before last accept, required 0", a, ifc3.done);
          end
        end
        send3(8'(bids[i]));
        if (i != 7) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      checks++;
      if (ifc3.done !== 1'b1 || ifc3.winner_idx !== 3'(e_idx) || ifc3.winner_onehot !== e_oh ||
          ifc3.winner_bid !== 8'(e_top) || ifc3.second_bid !== 8'(e_sec)) begin
        errors++;
        $display("FAIL rand%0d_result: done=%b idx=%0d oh=%h win=%0d sec=%0d, required 1 %0d %h %0d %0d",
                 a, ifc3.done, ifc3.winner_idx, ifc3.winner_onehot, ifc3.winner_bid, ifc3.second_bid,
                 e_idx, e_oh, e_top, e_sec);
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
      checks++;
      if (ifc3.done !== 1'b1 || ifc3.winner_idx !== 3'(e_idx) || ifc3.winner_bid !== 8'(e_top)) begin
        errors++;
        $display("FAIL rand%0d_hold: done=%b idx=%0d win=%0d, required 1 %0d %0d",
                 a, ifc3.done, ifc3.winner_idx, ifc3.winner_bid, e_idx, e_top);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    ifc2.start = 1'b0; ifc2.bid_valid = 1'b0; ifc2.bid = '0;
    ifc3.start = 1'b0; ifc3.bid_valid = 1'b0; ifc3.bid = '0;
    test_reset();
    test_distinct_max();
    test_tie();
    test_stall_ignored_start();
    test_back_to_back();
    test_reset_mid_scan();
    test_ascending();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within 400000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
